// File: rtl/fc2_argmax.sv
// fc2_argmax: FC2 layer MAC over N_IN streamed ReLU values, then sequential argmax over N_OUT classes.
// Optional macro FC2_SCORE_READ_EN adds a combinational per-class score read port.
module fc2_argmax #(
    parameter int N_IN  = 33,
    parameter int N_OUT = 10,
    parameter int W_W   = 8,
    parameter int ACC_W = 48
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    output logic [31:0]            counter2,
    input  logic [31:0]            r,
    output logic [5:0]             w_addr,
    input  logic [N_OUT*W_W-1:0]   w_data,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             digit,
    output logic [ACC_W-1:0]       max_score
`ifdef FC2_SCORE_READ_EN
    ,
    input  logic [3:0]             score_sel,
    output logic [ACC_W-1:0]       score
`endif
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ARGMAX, FIN} state_t;
    state_t state, state_n;
    logic [5:0] idx;
    logic mac_v;
    logic [3:0] cls, best_i, nb_i;
    logic last_in, last_cls, gt;
    logic signed [ACC_W-1:0] acc [N_OUT];
    logic signed [ACC_W-1:0] best, nb, cur;
    logic signed [31+W_W:0] p [N_OUT];
    for (genvar j = 0; j < N_OUT; j++) begin : g_mul
        assign p[j] = $signed(r) * $signed(w_data[j*W_W +: W_W]);
    end
    always_comb begin
        state_n  = state;
        last_in  = idx == 6'(N_IN - 1);
        last_cls = cls == 4'(N_OUT - 1);
        cur      = acc[cls];
        gt       = cur > best;
        nb       = gt ? cur : best;
        nb_i     = gt ? cls : best_i;
        case (state)
            IDLE:    state_n = start ? ISSUE : IDLE;
            ISSUE:   state_n = last_in ? DRAIN : ISSUE;
            DRAIN:   state_n = ARGMAX;
            ARGMAX:  state_n = last_cls ? FIN : ARGMAX;
            default: state_n = IDLE;
        endcase
    end
    assign counter2 = (state == ISSUE) ? {26'd0, idx} : 32'hFFFF_FFFF;
    assign busy     = state inside {ISSUE, DRAIN, ARGMAX};
    assign done     = state == FIN;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            idx       <= '0;
            mac_v     <= 1'b0;
            w_addr    <= '0;
            cls       <= '0;
            best      <= '0;
            best_i    <= '0;
            digit     <= '0;
            max_score <= '0;
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
        end else begin
            state  <= state_n;
            idx    <= (state == ISSUE) ? idx + 6'd1 : '0;
            mac_v  <= state == ISSUE;
            w_addr <= (state == ISSUE) ? idx : '0;
            cls    <= (state == ARGMAX) ? cls + 4'd1 : '0;
            // best starts at the most-negative value so any class can win
            best   <= (state == ARGMAX) ? nb : {1'b1, {(ACC_W-1){1'b0}}};
            best_i <= (state == ARGMAX) ? nb_i : '0;
            if (state == ARGMAX && last_cls) begin
                digit     <= nb_i;
                max_score <= nb;
            end
            for (int j = 0; j < N_OUT; j++) begin
                if (state == IDLE && start) acc[j] <= '0;
                else if (mac_v) acc[j] <= acc[j] + {{(ACC_W-32-W_W){p[j][31+W_W]}}, p[j]};
            end
        end
    end
`ifdef FC2_SCORE_READ_EN
    assign score = (score_sel < 4'(N_OUT)) ? acc[score_sel] : '0;
`endif
endmodule

// File: tb/tb_fc2_argmax.sv
// tb_fc2_argmax: directed checks of fc2_argmax with a registered ReLU source and combinational weight ROM.
module tb_fc2_argmax;
    logic clk = 1'b0, resetn, start;
    logic [31:0] counter2, r;
    logic [5:0] w_addr;
    logic [79:0] w_data;
    logic busy, done;
    logic [3:0] digit;
    logic [47:0] max_score;
    logic [31:0] rv [0:32];
    logic signed [7:0] wt [0:32][0:9];
    int checks = 0, errors = 0;
`ifdef FC2_SCORE_READ_EN
    logic [3:0] score_sel;
    logic [47:0] score;
`endif
    fc2_argmax dut (
        .clk(clk), .resetn(resetn), .start(start), .counter2(counter2), .r(r),
        .w_addr(w_addr), .w_data(w_data), .busy(busy), .done(done),
        .digit(digit), .max_score(max_score)
`ifdef FC2_SCORE_READ_EN
        , .score_sel(score_sel), .score(score)
`endif
    );
    always #5 clk = ~clk;
    always @(posedge clk) r <= (counter2 < 33) ? rv[counter2[5:0]] : 32'd0;
    always_comb begin
        w_data = '0;
        for (int j = 0; j < 10; j++) w_data[j*8 +: 8] = (w_addr < 33) ? wt[w_addr][j] : 8'd0;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic clr();
        for (int k = 0; k < 33; k++) begin
            rv[k] = 32'd0;
            for (int j = 0; j < 10; j++) wt[k][j] = 8'sd0;
        end
    endtask
    task automatic run(input string tag, input logic [3:0] ed, input logic [47:0] em, input int p1, input int p2);
        int dc = 0, dn = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            if (done) begin
                dn++;
                if (dc == 0) dc = n;
            end
            if (n == 1) begin
                chk({tag, ".busy1"}, 64'(busy), 64'd1);
                chk({tag, ".c2_first"}, 64'(counter2), 64'd0);
            end
            if (n == 33) chk({tag, ".c2_last"}, 64'(counter2), 64'd32);
            if (n == 34) begin
                chk({tag, ".c2_idle"}, 64'(counter2), 64'hFFFF_FFFF);
                chk({tag, ".waddr_drain"}, 64'(w_addr), 64'd32);
            end
            start = (n == p1 || n == p2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, ".done_cycle"}, 64'(dc), 64'd45);
        chk({tag, ".done_count"}, 64'(dn), 64'd1);
        chk({tag, ".digit"}, 64'(digit), 64'(ed));
        chk({tag, ".max_score"}, 64'(max_score), 64'(em));
    endtask
    initial begin
        int dn;
        resetn = 1'b0;
        start = 1'b0;
`ifdef FC2_SCORE_READ_EN
        score_sel = 4'd7;
`endif
        clr();
        #3;
        chk("rst.counter2", 64'(counter2), 64'hFFFF_FFFF);
        chk("rst.w_addr", 64'(w_addr), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.digit", 64'(digit), 64'd0);
        chk("rst.max_score", 64'(max_score), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        rv[32] = 32'd1;
        wt[32][3] = 8'sd5;
        run("bias_pulsed", 4'd3, 48'd5, 5, 30);
        run("bias_again", 4'd3, 48'd5, 0, 0);
        clr();
        rv[0] = 32'd2;
        wt[0][7] = -8'sd1;
        wt[0][2] = 8'sd1;
        run("signed", 4'd2, 48'd2, 0, 0);
`ifdef FC2_SCORE_READ_EN
        score_sel = 4'd7;
        #1 chk("score7", 64'(score), 64'(48'hFFFF_FFFF_FFFE));
        score_sel = 4'd12;
        #1 chk("score12", 64'(score), 64'd0);
`endif
        clr();
        rv[0] = 32'd10;
        wt[0][4] = 8'sd10;
        wt[0][6] = 8'sd10;
        run("tie", 4'd4, 48'd100, 0, 0);
        clr();
        rv[32] = 32'd1;
        for (int j = 0; j < 10; j++) wt[32][j] = 8'(j - 10);
        run("allneg", 4'd9, -48'sd1, 0, 0);
        clr();
        for (int k = 0; k < 32; k++) begin
            rv[k] = 32'd1000;
            wt[k][1] = 8'sd127;
            wt[k][5] = -8'sd128;
        end
        rv[32] = 32'd1;
        wt[32][0] = 8'sd100;
        run("multi", 4'd1, 48'd4064000, 0, 0);
        clr();
        rv[0] = 32'h8000_0000;
        wt[0][8] = -8'sd1;
        run("sign_r", 4'd8, 48'h0000_8000_0000, 0, 0);
        clr();
        rv[0] = 32'd10;
        wt[0][4] = 8'sd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        resetn = 1'b0;
        #1;
        chk("abort.counter2", 64'(counter2), 64'hFFFF_FFFF);
        chk("abort.w_addr", 64'(w_addr), 64'd0);
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.digit", 64'(digit), 64'd0);
        chk("abort.max_score", 64'(max_score), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        dn = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        chk("abort.no_done", 64'(dn), 64'd0);
        clr();
        rv[0] = 32'd2;
        wt[0][7] = -8'sd1;
        wt[0][2] = 8'sd1;
        run("after_abort", 4'd2, 48'd2, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fc2_argmax.md
FC2_ARGMAX -- requirements
Module: fc2_argmax

Interface
REQ-001 Parameter N_IN, default 33, number of FC2 inputs per inference: 32 ReLU values plus 1 bias pad.
REQ-002 Parameter N_OUT, default 10, number of output classes.
REQ-003 Parameter W_W, default 8, signed weight width.
REQ-004 Parameter ACC_W, default 48, signed accumulator width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to begin an inference.
REQ-008 counter2  output  32  index driven to the upstream ReLU stage; 0..32 selects an input, other values yield r=0.
REQ-009 r  input  32  registered ReLU result; value for index k is valid one cycle after counter2=k.
REQ-010 w_addr  output  6  weight-ROM row, equal to the index of the r value currently presented.
REQ-011 w_data  input  N_OUT*W_W  combinational ROM row; class j weight in bits [j*W_W +: W_W], signed.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle pulse; result valid.
REQ-014 digit  output  4  argmax class index, held until next done.
REQ-015 max_score  output  ACC_W  accumulator value of the winning class, held until next done.

Function
REQ-016 States IDLE, ISSUE, DRAIN, ARGMAX, FIN; FIN lasts exactly one cycle, then IDLE.
REQ-017 IDLE: start=1 clears all N_OUT accumulators, enters ISSUE; counter2 = 32'hFFFF_FFFF while not in ISSUE.
REQ-018 ISSUE: counter2 steps 0,1,...,N_IN-1, one per cycle, cycle 1..N_IN after start edge; then DRAIN.
REQ-019 MAC: in cycle k+2 (k = 0..N_IN-1), acc[j] += $signed(r) * $signed(w_data[j]) for all j in parallel; r treated signed 32-bit, product sign-extended to ACC_W; w_addr = k in that cycle, else 0.
REQ-020 DRAIN covers the final MAC cycle (cycle N_IN+1), then ARGMAX.
REQ-021 ARGMAX: one class per cycle, j = 0..N_OUT-1; running best initialised to the most-negative ACC_W value; update only on strictly greater, so ties resolve to lowest index.
REQ-022 FIN: done=1, digit/max_score updated same cycle; with defaults done asserts in cycle 45 after the start edge (cycle 0).
REQ-023 start while busy=1 or in FIN is ignored; no restart, no queueing.
REQ-024 Accumulator arithmetic wraps modulo 2^ACC_W; no saturation.
REQ-025 digit and max_score never change except at FIN.

Reset
REQ-026 resetn low: state IDLE, counter2=32'hFFFF_FFFF, w_addr=0, busy=0, done=0, digit=0, max_score=0, all accumulators 0, immediately and independent of clk.
REQ-027 Reset mid-inference aborts it; no done pulse; next inference requires a new start after resetn deasserts.

Configuration
REQ-028 Macro FC2_SCORE_READ_EN defined: adds input score_sel (4 bits) and output score (ACC_W bits), score = acc[score_sel] combinationally, 0 when score_sel >= N_OUT; accumulators hold after FIN until next start.
REQ-029 FC2_SCORE_READ_EN undefined: those ports and logic absent; all other behaviour identical.

Verification
REQ-030 Bias only: all r for index 0..31 = 0, r=1 at index 32, bias weights class 3 = 5, others 0 -> done at cycle 45, digit=3, max_score=5.
REQ-031 Signed MAC: r=2 at index 0 only, weight class 7 = -1, class 2 = +1, others 0 -> digit=2, max_score=2; with FC2_SCORE_READ_EN, score_sel=7 gives -2.
REQ-032 Tie: classes 4 and 6 both total 100, others less -> digit=4.
REQ-033 All-negative: every class total negative, class 9 = -1 highest -> digit=9, max_score=-1.
REQ-034 start pulsed at cycles 5 and 30 of a run -> ignored, single done at cycle 45; new start after done produces a second correct result with accumulators cleared.
REQ-035 resetn low at cycle 20 -> all outputs at reset values immediately, no done; fresh start then completes correctly in 45 cycles.
